ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 49 ++++
 rtl/ctrl_decode.sv | 51 +++++
 rtl/ctrl_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared types for the ctrl_seq control sequencer: opcode classes, FSM
// state encodings, the ALU pass-through code and the datapath strobe bundle.
package ctrl_seq_pkg;

  // Values match opcode[15:12] for the non-ALU classes; every 0xxx is ALU.
  typedef enum logic [3:0] {
    OPC_ALU  = 4'h0,
    OPC_LDI  = 4'h8,
    OPC_JMP  = 4'h9,
    OPC_JZ   = 4'hA,
    OPC_JC   = 4'hB,
    OPC_CALL = 4'hC,
    OPC_RET  = 4'hD,
    OPC_WAIT = 4'hE,
    OPC_HALT = 4'hF
  } op_class_e;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    RUN    = 3'd1,
    WAITEV = 3'd2,
    HALT   = 3'd3,
    FAULT  = 3'd4
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'b000;

  // Everything the sequencer drives into the datapath in one cycle.
  typedef struct packed {
    logic       pc_hold;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic       push;
    logic       pop;
    logic [2:0] op_alu;
  } ctrl_t;

  // Frozen PC with no writes: used in reset, WAITEV, HALT and FAULT.
  localparam ctrl_t CTRL_HOLD = '{pc_hold: 1'b1, s_inc: 1'b0, s_inm: 1'b0,
                                  we3: 1'b0, wez: 1'b0, push: 1'b0,
                                  pop: 1'b0, op_alu: ALU_PASS};

  function automatic op_class_e op_class(input logic [3:0] op);
    return op[3] ? op_class_e'(op) : OPC_ALU;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode-to-strobe decode, valid only while the
// sequencer is in RUN; ctrl_seq masks it in every other state.
module ctrl_decode
  import ctrl_seq_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic       i_z,
  input  logic       i_carry,
  output op_class_e  o_class,
  output ctrl_t      o_ctrl
);

  assign o_class = op_class(i_op);

  // Map the instruction class onto the datapath strobes.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // bit unassigned, which would otherwise infer a latch.
    o_ctrl       = '0;
    o_ctrl.s_inc = 1'b1;
    case (o_class)
      OPC_ALU: begin
        o_ctrl.op_alu = i_op[2:0];
        o_ctrl.we3    = 1'b1;
        o_ctrl.wez    = 1'b1;
      end
      OPC_LDI: begin
        o_ctrl.s_inm  = 1'b1;
        o_ctrl.op_alu = ALU_PASS;
        o_ctrl.we3    = 1'b1;
      end
      OPC_JMP: o_ctrl.s_inc = 1'b0;
      OPC_JZ:  o_ctrl.s_inc = ~i_z;
      OPC_JC:  o_ctrl.s_inc = ~i_carry;
      OPC_CALL: begin
        o_ctrl.push  = 1'b1;
        o_ctrl.s_inc = 1'b0;
      end
      OPC_RET: begin
        o_ctrl.pop   = 1'b1;
        o_ctrl.s_inc = 1'b0;
      end
      OPC_WAIT, OPC_HALT: begin
        o_ctrl.s_inc   = 1'b0;
        o_ctrl.pc_hold = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: control sequencer FSM (BOOT/RUN/WAITEV/HALT/FAULT) with a WAIT
// timeout counter. Define CTRL_SEQ_STACKCHK_EN to add a return-stack depth
// counter that faults on CALL overflow or RET underflow.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int WAIT_TO     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] opcode,
  input  logic        z,
  input  logic        carry,
  input  logic        ev_req,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic        push,
  output logic        pop,
  output logic [2:0]  op_alu,
  output logic        pc_hold,
  output logic        ev_ack,
  output logic        fault,
  output logic [2:0]  state_o
);

  // Last count value before the timeout fires; WAITEV lasts WAIT_TO cycles.
  localparam logic [7:0] TO_LAST = 8'(WAIT_TO - 1);

  state_e     r_state;
  logic [7:0] r_cnt;
  logic       r_fault;
  logic       r_ev_ack;

  op_class_e  w_class;
  ctrl_t      w_dec;
  ctrl_t      w_out;
  logic       w_call_ovf;
  logic       w_ret_unf;
  logic       w_unused_opcode;

  // Only the class nibble steers control; the rest belongs to the datapath.
  assign w_unused_opcode = ^opcode[11:0];

  ctrl_decode u_decode (
    .i_op    (opcode[15:12]),
    .i_z     (z),
    .i_carry (carry),
    .o_class (w_class),
    .o_ctrl  (w_dec)
  );

`ifdef CTRL_SEQ_STACKCHK_EN
  localparam int             DW        = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(STACK_DEPTH);

  logic [DW-1:0] r_depth;

  assign w_call_ovf = (w_class == OPC_CALL) && (r_depth == DEPTH_MAX);
  assign w_ret_unf  = (w_class == OPC_RET)  && (r_depth == '0);

  // Track return-stack occupancy for CALL/RET that actually reach the stack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (r_state == RUN) begin
      if (w_class == OPC_CALL && !w_call_ovf)
        r_depth <= r_depth + 1'b1;
      else if (w_class == OPC_RET && !w_ret_unf)
        r_depth <= r_depth - 1'b1;
    end
  end
`else
  localparam int unused_stack_depth = STACK_DEPTH;

  assign w_call_ovf = 1'b0;
  assign w_ret_unf  = 1'b0;
`endif

  // Strobes: decode passes through only in RUN; reset overrides everything.
  always_comb begin
    w_out = CTRL_HOLD;
    if (reset) begin
      case (r_state)
        BOOT: w_out.s_inc = 1'b1;
        RUN: begin
          w_out = w_dec;
          if (w_call_ovf) w_out.push = 1'b0;
          if (w_ret_unf)  w_out.pop  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM, WAIT timeout counter, sticky fault and event acknowledge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    if (!reset) begin
      r_state  <= BOOT;
      r_cnt    <= '0;
      r_fault  <= 1'b0;
      r_ev_ack <= 1'b0;
    end else begin
      r_ev_ack <= 1'b0;
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (w_call_ovf || w_ret_unf) begin
            r_fault <= 1'b1;
            r_state <= FAULT;
          end else if (w_class == OPC_WAIT) begin
            r_cnt   <= '0;
            r_state <= WAITEV;
          end else if (w_class == OPC_HALT) begin
            r_state <= HALT;
          end
        end
        WAITEV: begin
          if (ev_req) begin
            r_ev_ack <= 1'b1;
            r_state  <= RUN;
          end else if (r_cnt == TO_LAST) begin
            r_fault  <= 1'b1;
            r_state  <= FAULT;
          end else begin
            r_cnt    <= r_cnt + 8'd1;
          end
        end
        HALT, FAULT: ;
        default: r_state <= BOOT;
      endcase
    end
  end

  assign pc_hold = w_out.pc_hold;
  assign s_inc   = w_out.s_inc;
  assign s_inm   = w_out.s_inm;
  assign we3     = w_out.we3;
  assign wez     = w_out.wez;
  assign push    = w_out.push;
  assign pop     = w_out.pop;
  assign op_alu  = w_out.op_alu;
  assign ev_ack  = r_ev_ack;
  assign fault   = r_fault;
  assign state_o = r_state;

endmodule
